// File: rtl/pe_requant_stage_if.sv
// Result stream from pe_requant_stage toward the activation writeback path.
interface pe_requant_stage_if #(
   parameter int unsigned OUT_W = 8
) ();
   logic             valid;
   logic [OUT_W-1:0] data;
   logic             ready;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pe_requant_stage.sv
// Window-delta extraction, rounding requantization and output FIFO after the pe accumulator.
// Optional saturation counter enabled by defining PE_REQUANT_STATS_EN.
module pe_requant_stage #(
   parameter int unsigned ACC_W   = 32,
   parameter int unsigned OUT_W   = 8,
   parameter int unsigned SHIFT_W = 5,
   parameter int unsigned DEPTH   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_clear,
   input  logic               i_acc_valid,
   input  logic [ACC_W-1:0]   i_acc,
   input  logic               i_acc_last,
   input  logic [SHIFT_W-1:0] i_shift,
   input  logic               i_relu_en,
   output logic               o_acc_ready,
   pe_requant_stage_if.master res,
   output logic [15:0]        o_sat_cnt
);
   localparam int unsigned RW    = ACC_W + 1;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned USE_W = CNT_W + 1;
   localparam logic signed [RW-1:0] MAX_V = RW'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [RW-1:0] MIN_V = ~MAX_V;

   logic [ACC_W-1:0]        base;
   logic                    s1_v;
   logic [ACC_W-1:0]        s1_delta;
   logic [SHIFT_W-1:0]      s1_shift;
   logic                    s1_relu;
   logic                    s2_v;
   logic signed [RW-1:0]    s2_r;
   logic                    s2_relu;
   logic signed [RW-1:0]    d_ext;
   logic signed [RW-1:0]    rnd;
   logic signed [RW-1:0]    r_c;
   logic [OUT_W-1:0]        y_c;
   logic [OUT_W-1:0]        mem [DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [CNT_W-1:0]        count;
   logic [USE_W-1:0]        in_use;
   logic                    accept;
   logic                    push;
   logic                    pop;

   // Credit covers every result already committed to S1, S2 or the FIFO.
   assign in_use      = USE_W'(count) + USE_W'(s1_v) + USE_W'(s2_v);
   assign o_acc_ready = (in_use < USE_W'(DEPTH));
   assign accept      = i_acc_valid & i_acc_last & o_acc_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         base     <= '0;
         s1_v     <= 1'b0;
         s1_delta <= '0;
         s1_shift <= '0;
         s1_relu  <= 1'b0;
      end else begin
         s1_v <= accept;
         if (accept) begin
            s1_delta <= i_acc - base;
            s1_shift <= i_shift;
            s1_relu  <= i_relu_en;
         end
         if (accept || i_clear) base <= i_acc;
      end
   end

   // Round half up: add 2^(shift-1) in one extra bit of headroom, then arithmetic shift.
   always_comb begin
      d_ext = {s1_delta[ACC_W-1], s1_delta};
      rnd   = '0;
      if (s1_shift != '0) rnd = RW'(1) << (s1_shift - SHIFT_W'(1));
      r_c   = (d_ext + rnd) >>> s1_shift;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s2_v    <= 1'b0;
         s2_r    <= '0;
         s2_relu <= 1'b0;
      end else begin
         s2_v <= s1_v;
         if (s1_v) begin
            s2_r    <= r_c;
            s2_relu <= s1_relu;
         end
      end
   end

   always_comb begin
      y_c = s2_r[OUT_W-1:0];
      if (s2_relu && s2_r[RW-1]) y_c = '0;
      else if (s2_r > MAX_V)     y_c = MAX_V[OUT_W-1:0];
      else if (s2_r < MIN_V)     y_c = MIN_V[OUT_W-1:0];
   end

   assign push = s2_v;
   assign pop  = res.valid & res.ready;

   // Credit guarantees the FIFO never sees a push while full.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= y_c;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign res.valid = (count != '0);
   assign res.data  = mem[rd_ptr];

`ifdef PE_REQUANT_STATS_EN
   logic sat_c;

   // ReLU clamps of negative results are not saturation events.
   assign sat_c = !(s2_relu && s2_r[RW-1]) && ((s2_r > MAX_V) || (s2_r < MIN_V));

   always_ff @(posedge clk) begin
      if (reset) o_sat_cnt <= '0;
      else if (push && sat_c && (o_sat_cnt != 16'hFFFF)) o_sat_cnt <= o_sat_cnt + 16'd1;
   end
`else
   assign o_sat_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_requant_stage.sv
// Scoreboard bench for pe_requant_stage: model results queued on accept, compared on pop.
module tb_pe_requant_stage;
   localparam int unsigned ACC_W   = 32;
   localparam int unsigned OUT_W   = 8;
   localparam int unsigned SHIFT_W = 5;
   localparam int unsigned DEPTH   = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_clear;
   logic        i_acc_valid;
   logic [31:0] i_acc;
   logic        i_acc_last;
   logic [4:0]  i_shift;
   logic        i_relu_en;
   logic        o_acc_ready;
   logic [15:0] o_sat_cnt;

   pe_requant_stage_if #(.OUT_W(OUT_W)) res_if ();

   pe_requant_stage #(
      .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .i_clear(i_clear), .i_acc_valid(i_acc_valid),
      .i_acc(i_acc), .i_acc_last(i_acc_last), .i_shift(i_shift), .i_relu_en(i_relu_en),
      .o_acc_ready(o_acc_ready), .res(res_if), .o_sat_cnt(o_sat_cnt)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  exp_q[$];
   logic [31:0] base_m;
   int unsigned sat_m;
   logic        obs_valid;
   logic [7:0]  obs_data;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] requant(input logic [31:0] d, input int sh, input bit relu,
                                          output bit sat);
      longint sd;
      longint r;
      sd  = longint'($signed(d));
      r   = (sh == 0) ? sd : ((sd + (longint'(1) << (sh - 1))) >>> sh);
      sat = 1'b0;
      if (relu && r < 0) return 8'h00;
      if (r > 127) begin sat = 1'b1; return 8'h7F; end
      if (r < -128) begin sat = 1'b1; return 8'h80; end
      return r[7:0];
   endfunction

   function automatic logic [15:0] exp_sat();
`ifdef PE_REQUANT_STATS_EN
      return (sat_m > 32'hFFFF) ? 16'hFFFF : sat_m[15:0];
`else
      return 16'h0000;
`endif
   endfunction

   // One clock: drive, check credit and pops at the falling edge, advance the model.
   task automatic cycle(input bit clr, input bit v, input logic [31:0] acc, input bit last,
                        input int sh, input bit relu, input bit rdy);
      bit         exp_rdy;
      bit         acc_m;
      bit         sat;
      logic [7:0] y;
      i_clear      = clr;
      i_acc_valid  = v;
      i_acc        = acc;
      i_acc_last   = last;
      i_shift      = sh[4:0];
      i_relu_en    = relu;
      res_if.ready = rdy;
      @(negedge clk);
      obs_valid = res_if.valid;
      obs_data  = res_if.data;
      exp_rdy   = (exp_q.size() < DEPTH);
      check("acc_ready", o_acc_ready, exp_rdy);
      acc_m = v & last & exp_rdy;
      if (res_if.valid && exp_q.size() == 0) check("spurious_valid", res_if.valid, 0);
      else if (res_if.valid && rdy) check("data", res_if.data, exp_q.pop_front());
      if (acc_m) begin
         y = requant(acc - base_m, sh, relu, sat);
         exp_q.push_back(y);
         if (sat) sat_m++;
      end
      if (acc_m || clr) base_m = acc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit rdy);
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b0, rdy);
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      i_clear      = 1'b0;
      i_acc_valid  = 1'b0;
      i_acc        = '0;
      i_acc_last   = 1'b0;
      i_shift      = '0;
      i_relu_en    = 1'b0;
      res_if.ready = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      base_m = '0;
      sat_m  = 0;
      check("rst_valid", res_if.valid, 0);
      check("rst_data", res_if.data, 0);
      check("rst_ready", o_acc_ready, 1);
      check("rst_sat", o_sat_cnt, 0);
      reset = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1'b1);
      check("drain_empty", exp_q.size(), 0);
      repeat (3) idle(1'b1);
   endtask

   initial begin
      base_m = '0;
      sat_m  = 0;
      do_reset();

      // Basic result and N+3 latency.
      cycle(1, 0, 100, 0, 0, 0, 0);
      cycle(0, 1, 1100, 1, 3, 0, 0);
      idle(0); check("lat_n1_valid", obs_valid, 0);
      idle(0); check("lat_n2_valid", obs_valid, 0);
      idle(0); check("lat_n3_valid", obs_valid, 1);
      check("lat_n3_data", obs_data, 8'h7D);
      drain();
      check("basic_sat", o_sat_cnt, exp_sat());

      // Negative saturation, then the same delta clamped by ReLU.
      do_reset();
      cycle(0, 1, 32'hFFFFF000, 1, 4, 0, 1);
      drain();
      check("sat_cnt_1", o_sat_cnt, exp_sat());
      cycle(1, 0, 32'h0, 0, 0, 0, 1);
      cycle(0, 1, 32'hFFFFF000, 1, 4, 1, 1);
      drain();
      check("relu_sat_cnt", o_sat_cnt, exp_sat());

      // Accumulator wrap between windows.
      cycle(1, 0, 32'hFFFFFFF0, 0, 0, 0, 1);
      cycle(0, 1, 32'h00000010, 1, 0, 0, 1);
      drain();

      // Backpressure: six back-to-back last beats, only four fit.
      cycle(1, 0, 32'h0, 0, 0, 0, 0);
      for (int k = 1; k <= 6; k++) cycle(0, 1, 32'(k * 10), 1, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         idle(0);
         if (obs_valid) check("stall_data", obs_data, exp_q[0]);
      end
      check("stall_valid", obs_valid, 1);
      drain();
      cycle(0, 1, 32'd100, 1, 0, 0, 1);
      drain();

      // Rounding corners.
      cycle(1, 0, 32'd1000, 0, 0, 0, 1);
      cycle(0, 1, 32'd1003, 1, 1, 0, 1);
      cycle(0, 1, 32'd1000, 1, 1, 0, 1);
      cycle(0, 1, 32'd999, 1, 0, 0, 1);
      drain();

      // Clear coincident with an accepted last beat still yields a result.
      cycle(1, 1, 32'd1050, 1, 0, 0, 1);
      drain();

      // Reset while two results are in flight.
      cycle(1, 0, 32'h0, 0, 0, 0, 1);
      cycle(0, 1, 32'd5, 1, 0, 0, 1);
      cycle(0, 1, 32'd7, 1, 0, 0, 1);
      do_reset();
      repeat (5) idle(1'b1);
      check("post_rst_valid", obs_valid, 0);
      cycle(0, 1, 32'd9, 1, 0, 0, 1);
      drain();

      // Random traffic with random backpressure.
      for (int k = 0; k < 300; k++) begin
         cycle($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, $urandom(),
               $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
               $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
      end
      drain();
      check("final_sat", o_sat_cnt, exp_sat());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
